// File: rtl/serial_complement_unit_pkg.sv
// Shared encodings for the bit-serial complement unit.
`default_nettype none

package serial_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_CAPT = 1'b1
  } cap_state_e;

  typedef enum logic [0:0] {
    EMT_IDLE = 1'b0,
    EMT_EMIT = 1'b1
  } emit_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_complement_unit_if.sv
// Framed serial input / transformed serial output bundle shared by all lanes.
`default_nettype none

interface serial_complement_unit_if #(
  parameter int LANES = 2
);
  logic             clr;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_first;
  logic [LANES-1:0] data_in;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic [LANES-1:0] data_out;
  logic [LANES-1:0] ovf;
  logic             frame_err;

  modport master (
    output clr, mode, in_valid, in_first, data_in,
    input  out_valid, out_first, out_last, data_out, ovf, frame_err
  );

  modport slave (
    input  clr, mode, in_valid, in_first, data_in,
    output out_valid, out_first, out_last, data_out, ovf, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/serial_complement_unit_lane.sv
// One serial lane: capture shift register, emit buffer, carry-seen flag and overflow detect.
`default_nettype none

module serial_complement_lane
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic          load_i,
  input  logic          emit_i,
  input  logic          last_i,
  input  logic [CW-1:0] idx_i,
  input  logic [1:0]    mode_i,
  input  logic          bit_i,
  output logic          data_o,
  output logic          ovf_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] emit_q;
  logic             d_q;
  logic             ebit;
  logic             negate;

  // LSB arrives first, so shifting right leaves bit 0 at position 0 after WIDTH bits.
  assign cap_d  = {bit_i, cap_q[WIDTH-1:1]};
  assign ebit   = emit_q[idx_i];
  assign negate = (mode_i == MODE_NEG) || ((mode_i == MODE_ABS) && emit_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      cap_q  <= '0;
      emit_q <= '0;
      d_q    <= 1'b0;
    end else begin
      if (shift_i) begin
        cap_q <= cap_d;
      end
      if (load_i) begin
        emit_q <= cap_d;
        d_q    <= 1'b0;
      end else if (emit_i) begin
        d_q <= d_q | ebit;
      end
    end
  end

  always_comb begin
    data_o = 1'b0;
    if (emit_i) begin
      if (mode_i == MODE_ONES) begin
        data_o = ~ebit;
      end else if (negate) begin
        data_o = ebit ^ d_q;
      end else begin
        data_o = ebit;
      end
    end
  end

  assign ovf_o = last_i && ((mode_i == MODE_NEG) || (mode_i == MODE_ABS)) && (emit_q == MOST_NEG);

endmodule

`default_nettype wire

// File: rtl/serial_complement_unit.sv
// Multi-lane bit-serial pass / ones' / two's complement / abs unit with framed, double-buffered lanes.
`default_nettype none

module serial_complement_unit
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_complement_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  cap_state_e       cap_q;
  emit_state_e      emt_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    idx_q;
  logic [1:0]       cmode_q;
  logic [1:0]       emode_q;
  logic             ferr_q;
  logic             shift;
  logic             load;
  logic             emitting;
  logic             last;
  logic [LANES-1:0] lane_data;
  logic [LANES-1:0] lane_ovf;

  assign shift    = bus.in_valid && (bus.in_first || (cap_q == CAP_CAPT));
  assign load     = bus.in_valid && !bus.in_first && (cap_q == CAP_CAPT) && (cnt_q == LAST_IDX);
  assign emitting = (emt_q == EMT_EMIT);
  assign last     = emitting && (idx_q == LAST_IDX);

  // in_first always (re)starts a frame; it is an error only if it cuts a partial word short.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      cap_q   <= CAP_IDLE;
      cnt_q   <= '0;
      cmode_q <= MODE_PASS;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_first) begin
          cap_q   <= CAP_CAPT;
          cnt_q   <= CW'(1);
          cmode_q <= bus.mode;
          ferr_q  <= (cap_q == CAP_CAPT);
        end else if (cap_q == CAP_IDLE) begin
          ferr_q <= 1'b1;
        end else if (load) begin
          cap_q <= CAP_IDLE;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // A load takes priority so a word landing on the final emit cycle follows without a gap.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      emt_q   <= EMT_IDLE;
      idx_q   <= '0;
      emode_q <= MODE_PASS;
    end else if (load) begin
      emt_q   <= EMT_EMIT;
      idx_q   <= '0;
      emode_q <= cmode_q;
    end else if (emitting) begin
      if (idx_q == LAST_IDX) begin
        emt_q <= EMT_IDLE;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + CW'(1);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serial_complement_lane #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (bus.clr),
      .shift_i (shift),
      .load_i  (load),
      .emit_i  (emitting),
      .last_i  (last),
      .idx_i   (idx_q),
      .mode_i  (emode_q),
      .bit_i   (bus.data_in[l]),
      .data_o  (lane_data[l]),
      .ovf_o   (lane_ovf[l])
    );
  end

  assign bus.out_valid = emitting;
  assign bus.out_first = emitting && (idx_q == '0);
  assign bus.out_last  = last;
  assign bus.data_out  = lane_data;
  assign bus.ovf       = lane_ovf;
  assign bus.frame_err = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_complement_unit.sv
// Randomised bench for serial_complement_unit against a word-level arithmetic model.
`default_nettype none

module tb_serial_complement_unit;
  import serial_pkg::*;

  localparam int W = 8;
  localparam int L = 2;

  typedef logic [L-1:0][W-1:0] word_t;
  typedef struct packed {
    word_t          data;
    logic [L-1:0]   ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_complement_unit_if #(.LANES(L)) sif ();

  serial_complement_unit #(
    .WIDTH (W),
    .LANES (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int    checks     = 0;
  int    errors     = 0;
  int    fe_cnt     = 0;
  int    words_seen = 0;
  int    bi         = 0;
  exp_t  exp_q[$];
  time   first_t[$];
  word_t acc;
  exp_t  mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [1:0] m, input logic [W-1:0] w);
    logic [W-1:0] neg;
    neg = W'(0) - w;
    case (m)
      MODE_PASS: return w;
      MODE_ONES: return ~w;
      MODE_NEG:  return neg;
      default:   return w[W-1] ? neg : w;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [1:0] m, input logic [W-1:0] w);
    logic [W-1:0] most_neg;
    most_neg = '0;
    most_neg[W-1] = 1'b1;
    return ((m == MODE_NEG) || (m == MODE_ABS)) && (w == most_neg);
  endfunction

  // Output monitor: reassembles words and scores them against the expected queue.
  always @(posedge clk) begin
    #1;
    if (sif.frame_err) fe_cnt++;
    if (!sif.out_valid) begin
      check("idle_zero", {sif.out_first, sif.out_last, sif.data_out, sif.ovf}, 0);
    end else begin
      if (sif.out_first) begin
        bi = 0;
        first_t.push_back($time);
      end
      if (bi < W) begin
        for (int l = 0; l < L; l++) acc[l][bi] = sif.data_out[l];
      end
      if (sif.out_last) begin
        words_seen++;
        check("last_position", bi, W - 1);
        check("word_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          for (int l = 0; l < L; l++) check("lane_data", acc[l], mon_e.data[l]);
          check("ovf", sif.ovf, mon_e.ovf);
        end
      end else begin
        check("ovf_not_last", sif.ovf, 0);
      end
      bi++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sif.in_valid = 1'b0;
      sif.in_first = 1'b0;
      sif.data_in  = '0;
    end
  endtask

  task automatic drive_bit(input logic first, input logic [L-1:0] b, input logic [1:0] m);
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_first = first;
    sif.data_in  = b;
    sif.mode     = m;
  endtask

  task automatic send_frame(input logic [1:0] m, input word_t w, input bit gaps,
                            input int nbits, input bit expect_out);
    exp_t e;
    for (int b = 0; b < nbits; b++) begin
      logic [L-1:0] v;
      if (gaps && b > 0) idle($urandom_range(0, 2));
      for (int l = 0; l < L; l++) v[l] = w[l][b];
      drive_bit(b == 0, v, m);
    end
    if (expect_out) begin
      for (int l = 0; l < L; l++) begin
        e.data[l] = model_word(m, w[l]);
        e.ovf[l]  = model_ovf(m, w[l]);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check("latency_out_first", sif.out_first, 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain_complete", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int l = 0; l < L; l++) w[l] = W'($urandom());
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int ws0;
    int n0;
    sif.clr      = 1'b0;
    sif.mode     = MODE_PASS;
    sif.in_valid = 1'b0;
    sif.in_first = 1'b0;
    sif.data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {sif.out_valid, sif.out_first, sif.out_last, sif.data_out,
                          sif.ovf, sif.frame_err}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed words
    send_frame(MODE_NEG, {8'h00, 8'h05}, 0, W, 1);
    idle(1);
    drain();
    send_frame(MODE_ABS, {8'h0A, 8'hF6}, 0, W, 1);
    idle(2);
    send_frame(MODE_ONES, {8'h3C, 8'h3C}, 0, W, 1);
    idle(2);
    send_frame(MODE_PASS, {8'h3C, 8'h3C}, 0, W, 1);
    idle(1);
    drain();
    send_frame(MODE_NEG, {8'h7F, 8'h80}, 0, W, 1);
    idle(1);
    drain();
    send_frame(MODE_ABS, {8'h80, 8'h01}, 0, W, 1);
    idle(1);
    drain();

    // Back-to-back frames
    fe0 = fe_cnt;
    n0  = first_t.size();
    send_frame(MODE_NEG, rand_word(), 0, W, 1);
    send_frame(MODE_ABS, rand_word(), 0, W, 1);
    send_frame(2'($urandom_range(0, 3)), rand_word(), 1, W, 1);
    idle(1);
    drain();
    check("b2b_frame_err", fe_cnt - fe0, 0);
    check("b2b_contiguous", (first_t.size() > n0 + 1) ? 32'(first_t[n0 + 1] - first_t[n0]) : 0, W * 10);

    // Truncated frame followed by a full one
    fe0 = fe_cnt;
    ws0 = words_seen;
    send_frame(MODE_PASS, rand_word(), 0, 3, 0);
    send_frame(MODE_NEG, {8'h05, 8'h05}, 0, W, 1);
    idle(1);
    drain();
    check("trunc_frame_err", fe_cnt - fe0, 1);
    check("trunc_words", words_seen - ws0, 1);

    // Lone valid bit without in_first
    fe0 = fe_cnt;
    ws0 = words_seen;
    drive_bit(1'b0, 2'b11, MODE_PASS);
    idle(W + 4);
    check("lone_frame_err", fe_cnt - fe0, 1);
    check("lone_no_output", words_seen - ws0, 0);

    // Random traffic
    for (int i = 0; i < 16; i++) begin
      send_frame(2'($urandom_range(0, 3)), rand_word(), 1, W, 1);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset mid-emission
    send_frame(MODE_NEG, rand_word(), 0, W, 1);
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_emit", {sif.out_valid, sif.out_first, sif.out_last, sif.data_out,
                           sif.ovf, sif.frame_err}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    send_frame(MODE_ABS, rand_word(), 0, W, 1);
    idle(1);
    drain();

    // Clear mid-capture
    fe0 = fe_cnt;
    ws0 = words_seen;
    send_frame(MODE_ONES, rand_word(), 0, 4, 0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    sif.in_first = 1'b0;
    sif.clr      = 1'b1;
    @(negedge clk);
    sif.clr = 1'b0;
    send_frame(MODE_NEG, rand_word(), 0, W, 1);
    idle(1);
    drain();
    check("clr_frame_err", fe_cnt - fe0, 0);
    check("clr_words", words_seen - ws0, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_complement_unit.md
Name: serial_complement_unit

Overview:
- Multi-lane, bit-serial, LSB-first word transformer: pass, ones' complement, two's complement negate, or absolute value.
- Generalises the single-bit serial negator: parametrised word length and lane count, framed input, mode select, and overflow detection.
- Each lane buffers one full word before re-emitting it, which makes abs possible because the sign bit arrives last.
- Sits between serial datapath stages; all lanes share framing and mode.

Parameters:
- WIDTH, 8, bits per serial word (>= 2).
- LANES, 2, number of parallel serial lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- clr  in  1  synchronous clear, active-high; aborts all in-flight frames.
- mode  in  2  00 pass, 01 ones' complement, 10 two's complement, 11 abs; sampled on the in_first bit.
- in_valid  in  1  current input bit valid on all lanes.
- in_first  in  1  qualifies the LSB (bit 0) of a frame; meaningful only with in_valid.
- data_in  in  LANES  one serial bit per lane.
- out_valid  out  1  output bit valid.
- out_first  out  1  output bit is the LSB.
- out_last  out  1  output bit is the MSB.
- data_out  out  LANES  transformed serial bits.
- ovf  out  LANES  per-lane overflow; valid only with out_last.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst==0 at clk edge) or clr==1:
  - All outputs go to 0 next cycle.
  - Input bit counter cleared; capture and emit registers cleared; emitter idle.
  - rst has priority over clr; both act identically.
- Input capture FSM, states IDLE and CAPT:
  - IDLE: in_valid & in_first -> store bit 0, latch mode, counter=1, go to CAPT. in_valid without in_first -> ignored, frame_err pulse.
  - CAPT: each in_valid bit shifts into the lane capture register and increments the counter. in_valid low is a stall: hold state, no error.
  - CAPT with in_valid & in_first before WIDTH bits -> discard partial word, frame_err pulse, restart capture with this bit as bit 0 and re-latch mode.
  - Bit WIDTH-1 accepted -> transfer word plus latched mode to the emit registers; counter=0; go to IDLE.
  - A new in_first in the cycle after transfer is legal (back-to-back frames).
- Emitter FSM, states IDLE and EMIT:
  - On transfer it enters EMIT with index 0 and per-lane flag d=0.
  - Emits one bit per cycle, LSB first, for exactly WIDTH cycles. No backpressure.
  - Because input needs >= WIDTH cycles per word, a transfer never collides with an active emission (double-buffered).
  - If a transfer coincides with the final emit cycle, the next word starts on the following cycle without a gap.
- Latency: out_first is asserted the cycle after the edge that samples input bit WIDTH-1.
- Output bit b per lane, with bit = emit register bit b:
  - pass: data_out = bit.
  - ones' complement: data_out = ~bit.
  - two's complement: data_out = bit ^ d; d <= d | bit.
  - abs: two's-complement rule if the buffered MSB is 1, else pass.
- ovf (asserted with out_last): lane word == 1 followed by WIDTH-1 zeros, in mode 10 or 11. The result is the unchanged 10..0. Otherwise ovf = 0.
- out_valid / out_first / out_last / data_out / ovf are 0 whenever the emitter is idle.
- clr or reset mid-emission truncates the word; no partial completion.

Decomposition:
- Shared package serial_pkg:
  - mode encodings MODE_PASS, MODE_ONES, MODE_NEG, MODE_ABS;
  - capture/emit state encodings.
- Sub-module serial_complement_lane, instantiated LANES times:
  - holds the capture register, emit register, d flag and ovf logic;
  - takes shared shift/load/emit-index strobes.
- Top level holds both FSMs, the counters and frame_err.

Test Plan:
- WIDTH=8, LANES=2, mode=10, lane0=0x05, lane1=0x00 -> lane0 emits 0xFB, lane1 emits 0x00, ovf=00; out_first exactly 1 cycle after MSB sample.
- mode=11, lane0=0xF6, lane1=0x0A -> both emit 0x0A; then mode=01 on 0x3C -> 0xC3; mode=00 on 0x3C -> 0x3C.
- mode=10, lane0=0x80, lane1=0x7F -> lane0 emits 0x80 with ovf[0]=1 on out_last; lane1 emits 0x81 with ovf[1]=0.
- Back-to-back frames, the second with random in_valid gaps -> contiguous, correct output words; no frame_err.
- in_first after 3 bits, then a full frame 0x05 in mode 10 -> frame_err single pulse; only 0xFB is emitted. Lone in_valid without in_first in IDLE -> frame_err pulse, no output.
- rst=0 mid-emission -> all outputs 0 on the next cycle. clr=1 mid-capture -> word discarded and the next clean frame is correct.
